// File: rtl/exp10_to_complex_reader.sv
// -----------------------------------------------------------------------------
// exp10_to_complex_reader
//
// Decodes block-floating-point complex samples held in the acquisition sample
// buffer. Each 24-bit buffer word carries a 10-bit I mantissa, a 10-bit Q
// mantissa and a 4-bit shared exponent. A start/length command walks the buffer
// sequentially, expands every word to 16-bit signed I/Q and streams the results
// out under a valid/ready handshake. A 2-entry FIFO absorbs the buffer's
// 1-cycle read latency so the stream can sustain one sample per cycle.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           one-cycle command pulse, ignored while busy
//   start_addr      first buffer address, sampled with start
//   length          sample count 0..2^ADDR_WIDTH, sampled with start
//   abort           synchronous cancel of the current command
//   busy            command in progress
//   done            one-cycle pulse after the last sample is accepted
//   mem_rd          buffer read strobe
//   mem_addr        buffer read address, valid with mem_rd
//   mem_rdata       read data, valid one cycle after mem_rd
//   out_valid       output sample valid
//   out_ready       downstream ready
//   out_i, out_q    expanded 16-bit two's complement I/Q
//   exp_err         sticky flag: an exponent above 6 was decoded
// -----------------------------------------------------------------------------
module exp10_to_complex_reader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [23:0]           mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_i,
  output logic [15:0]           out_q,
  output logic                  exp_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q;
  logic                  done_q, done_d;
  logic                  exp_err_q, exp_err_d;

  // Output FIFO: two already-expanded I/Q entries
  logic [15:0] fifo_ich_q [2];
  logic [15:0] fifo_qch_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;

  logic        pop;
  logic        push;
  logic        rd_issue;
  logic [2:0]  occupancy;

  // Decode of the word returning from the buffer
  logic [9:0]  mant_ich;
  logic [9:0]  mant_qch;
  logic [3:0]  exp_raw;
  logic        exp_bad;
  logic [2:0]  shift;
  logic [15:0] dec_ich;
  logic [15:0] dec_qch;

  assign mant_ich = mem_rdata[23:14];
  assign mant_qch = mem_rdata[13:4];
  assign exp_raw  = mem_rdata[3:0];
  // Exponents above 6 would overflow 16 bits; clamp to 6 and flag it.
  assign exp_bad  = (exp_raw > 4'd6);
  assign shift    = exp_bad ? 3'd6 : exp_raw[2:0];
  assign dec_ich  = {{6{mant_ich[9]}}, mant_ich} << shift;
  assign dec_qch  = {{6{mant_qch[9]}}, mant_qch} << shift;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  // Read data arriving during an abort cycle belongs to the cancelled command.
  assign push      = inflight_q & ~abort;

  // Samples buffered plus in flight, as they will stand after this cycle's pop.
  // Issuing a read only while this is below 2 keeps the FIFO from overflowing.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign rd_issue = (state_q == ST_RUN) && !abort &&
                    (remaining_q != '0) && (occupancy < 3'd2);

  assign mem_rd   = rd_issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign exp_err  = exp_err_q;
  assign out_i    = fifo_ich_q[rd_ptr_q];
  assign out_q    = fifo_qch_q[rd_ptr_q];

  // Next-state and command bookkeeping
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    exp_err_d   = exp_err_q;

    if (push && exp_bad) begin
      exp_err_d = 1'b1;
    end

    if (abort) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            exp_err_d = 1'b0;
            if (length != '0) begin
              state_d     = ST_RUN;
              addr_d      = start_addr;
              remaining_d = length;
            end else begin
              // Empty command completes immediately without touching the buffer.
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (rd_issue) begin
            addr_d      = addr_q + 1'b1;  // wraps naturally at the top of the buffer
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Nothing in flight and the last buffered sample leaves this cycle.
          if (occupancy == 3'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      exp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= rd_issue;
      done_q      <= done_d;
      exp_err_q   <= exp_err_d;
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        fifo_ich_q[k] <= '0;
        fifo_qch_q[k] <= '0;
      end
    end else if (abort) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_ich_q[wr_ptr_q] <= dec_ich;
        fifo_qch_q[wr_ptr_q] <= dec_qch;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_exp10_to_complex_reader.sv
// -----------------------------------------------------------------------------
// Bench for exp10_to_complex_reader: a buffer model with 1-cycle read latency,
// an expected-sample queue filled from the buffer contents when a command is
// issued, and a compare process that checks every accepted sample, every read
// address, the outstanding-read bound and output stability under back-pressure.
// Directed sequences add cycle-exact literal checks.
// -----------------------------------------------------------------------------
module tb_exp10_to_complex_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [23:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic        exp_err;

  exp10_to_complex_reader #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .exp_err   (exp_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample buffer model: data valid exactly one cycle after the read strobe
  logic [23:0] mem [1024];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 24'hA5A5A5;
  end

  // Scoreboard state
  logic [31:0] exp_fifo[$];
  logic [9:0]  addr_log[$];
  int          exp_addr     = 0;
  int          n_rd         = 0;
  int          n_acc        = 0;
  int          done_cnt     = 0;
  int          done_cyc     = 0;
  int          last_acc_cyc = 0;
  logic        prev_stall   = 1'b0;
  logic [15:0] prev_i       = '0;
  logic [15:0] prev_q       = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference expansion: signed mantissa times 2^exp, exponents above 6 use 6
  function automatic logic [15:0] expand(input logic [9:0] m, input logic [3:0] e);
    int v;
    int s;
    v = $signed(m);
    s = (e > 4'd6) ? 6 : int'(e);
    return 16'(v * (1 << s));
  endfunction

  function automatic logic [23:0] pk(input logic [9:0] mi, input logic [9:0] mq, input logic [3:0] e);
    return {mi, mq, e};
  endfunction

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_i", out_i, prev_i);
        chk("hold_q", out_q, prev_q);
      end
      if (mem_rd) begin
        chk("mem_addr", mem_addr, exp_addr);
        addr_log.push_back(mem_addr);
        exp_addr = (exp_addr + 1) % 1024;
        n_rd++;
      end
      if (out_valid && out_ready) begin
        n_acc++;
        last_acc_cyc = cyc;
        chk("sample_expected", exp_fifo.size() != 0, 1'b1);
        if (exp_fifo.size() != 0) begin
          e = exp_fifo.pop_front();
          chk("out_i", out_i, e[31:16]);
          chk("out_q", out_q, e[15:0]);
        end
      end
      if (mem_rd) chk("outstanding_le2", (n_rd - n_acc) <= 2, 1'b1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready && !abort;
      prev_i     = out_i;
      prev_q     = out_q;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a command in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_cmd(input int addr, input int len);
    logic [23:0] w;
    exp_fifo.delete();
    addr_log.delete();
    n_rd     = 0;
    n_acc    = 0;
    exp_addr = addr;
    for (int k = 0; k < len; k++) begin
      w = mem[(addr + k) % 1024];
      exp_fifo.push_back({expand(w[23:14], w[3:0]), expand(w[13:4], w[3:0])});
    end
    start      = 1'b1;
    start_addr = 10'(addr);
    length     = 11'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base;
    int k;
    base = done_cnt;
    k    = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    chk(name, done_cnt != base, 1'b1);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'h000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_i", out_i, 16'h0000);
    chk("rst_out_q", out_q, 16'h0000);
    chk("rst_exp_err", exp_err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit, required $finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] t1_i [4] = '{16'h01FF, 16'h0008, 16'h5540, 16'h8000};
  logic [15:0] t1_q [4] = '{16'hFE00, 16'hFFF8, 16'h2A80, 16'h7FC0};

  initial begin
    int base;

    for (int a = 0; a < 1024; a++) mem[a] = 24'($urandom);
    mem[0] = pk(10'h1FF, 10'h200, 4'd0);
    mem[1] = pk(10'h001, 10'h3FF, 4'd3);
    mem[2] = pk(10'h155, 10'h0AA, 4'd6);
    mem[3] = pk(10'h200, 10'h1FF, 4'd6);
    for (int k = 0; k < 8; k++)  mem[16 + k]  = pk(10'(k * 37 + 5), 10'(1000 - k * 91), 4'(k % 7));
    for (int k = 0; k < 4; k++)  mem[40 + k]  = pk(10'(k * 100), 10'(k * 3), 4'(k));
    mem[100]  = pk(10'h001, 10'h3FF, 4'd9);
    for (int k = 0; k < 16; k++) mem[200 + k] = pk(10'(k * 61), 10'(k * 13 + 7), 4'(k % 5));
    for (int k = 0; k < 8; k++)  mem[300 + k] = pk(10'(k + 1), 10'(k + 2), 4'd2);
    mem[1022] = pk(10'h123, 10'h321, 4'd1);
    mem[1023] = pk(10'h3FF, 10'h001, 4'd4);

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b1;

    // Reset values, during reset and after release
    tick();
    tick();
    chk_outputs_zero();
    rst = 1'b0;
    tick();
    chk_outputs_zero();

    // Model pinned to hand-computed values
    chk("model_pin_a", expand(10'h200, 4'd6), 16'h8000);
    chk("model_pin_b", expand(10'h001, 4'd9), 16'h0040);

    // Four words, ready high: cycle-exact literal outputs
    start_cmd(0, 4);
    for (int c = 1; c <= 7; c++) begin
      chk("t1_mem_rd", mem_rd, c <= 4);
      chk("t1_busy", busy, c <= 6);
      chk("t1_valid", out_valid, c >= 3 && c <= 6);
      chk("t1_done", done, c == 7);
      if (c >= 3 && c <= 6) begin
        chk("t1_i", out_i, t1_i[c - 3]);
        chk("t1_q", out_q, t1_q[c - 3]);
      end
      tick();
    end
    chk("t1_exp_err", exp_err, 1'b0);
    chk("t1_drained", exp_fifo.size(), 0);

    // Eight words with ready toggling each cycle
    base = done_cnt;
    start_cmd(16, 8);
    for (int k = 1; k < 80 && done_cnt == base; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    chk("tog_done_once", done_cnt, base + 1);
    chk("tog_accepts", n_acc, 8);
    chk("tog_done_latency", done_cyc, last_acc_cyc + 1);
    chk("tog_drained", exp_fifo.size(), 0);

    // Address wrap at the top of the buffer
    start_cmd(1022, 4);
    wait_done(20, "wrap_done");
    chk("wrap_reads", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", addr_log[0], 10'h3FE);
      chk("wrap_a1", addr_log[1], 10'h3FF);
      chk("wrap_a2", addr_log[2], 10'h000);
      chk("wrap_a3", addr_log[3], 10'h001);
    end

    // Start while busy is ignored
    base = done_cnt;
    start_cmd(40, 4);
    tick();
    start      = 1'b1;
    start_addr = 10'd500;
    length     = 11'd2;
    tick();
    start = 1'b0;
    wait_done(20, "busy_start_done");
    tick();
    tick();
    tick();
    chk("busy_start_accepts", n_acc, 4);
    chk("busy_start_reads", n_rd, 4);
    chk("busy_start_done_once", done_cnt, base + 1);

    // Out-of-range exponent: clamped expansion and sticky flag
    start_cmd(100, 1);
    tick();
    tick();
    chk("experr_valid", out_valid, 1'b1);
    chk("experr_i", out_i, 16'h0040);
    chk("experr_q", out_q, 16'hFFC0);
    chk("experr_flag", exp_err, 1'b1);
    wait_done(20, "experr_done");
    tick();
    chk("experr_sticky", exp_err, 1'b1);

    // Zero-length command: done next cycle, no reads, clears exp_err
    start_cmd(0, 0);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    chk("len0_mem_rd", mem_rd, 1'b0);
    chk("len0_exp_err_clr", exp_err, 1'b0);
    tick();
    chk("len0_done_pulse", done, 1'b0);
    tick();
    chk("len0_no_reads", n_rd, 0);

    // Abort at cycle 4 of a 16-word command
    base = done_cnt;
    start_cmd(200, 16);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", out_valid, 1'b0);
    exp_fifo.delete();
    for (int k = 0; k < 6; k++) begin
      chk("abort_idle_rd", mem_rd, 1'b0);
      chk("abort_idle_valid", out_valid, 1'b0);
      tick();
    end
    chk("abort_no_done", done_cnt, base);

    // Abort and start together: abort wins
    base       = done_cnt;
    start      = 1'b1;
    abort      = 1'b1;
    start_addr = 10'd300;
    length     = 11'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("abst_busy", busy, 1'b0);
      chk("abst_mem_rd", mem_rd, 1'b0);
      tick();
    end
    chk("abst_no_done", done_cnt, base);

    // Reset mid-command with the FIFO holding data
    out_ready = 1'b0;
    start_cmd(300, 8);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero();
    exp_fifo.delete();
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("postrst_busy", busy, 1'b0);
      chk("postrst_valid", out_valid, 1'b0);
      chk("postrst_mem_rd", mem_rd, 1'b0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exp10_to_complex_reader.md
# exp10_to_complex_reader

Reads packed 10-bit-mantissa/shared-exponent complex samples from the acquisition engine sample buffer and expands them back to 16-bit signed I/Q. It is the decode side of the buffer's block-floating-point packing: a start/length command drives sequential buffer reads, and the block streams 16-bit samples to downstream correlation or debug readout under a valid/ready handshake. A 2-entry output FIFO sustains one sample per cycle across the buffer's 1-cycle read latency.

## Interface
- ADDR_WIDTH, 10, sample buffer address width; depth 2^ADDR_WIDTH words
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse; ignored while busy
- start_addr  in  ADDR_WIDTH  first buffer address, sampled with start
- length  in  ADDR_WIDTH+1  samples to read, 0..2^ADDR_WIDTH, sampled with start
- abort  in  1  synchronous cancel of the current command
- busy  out  1  high from the cycle after accepted start until done/abort
- done  out  1  one-cycle pulse when the last sample has been accepted downstream
- mem_rd  out  1  buffer read strobe
- mem_addr  out  ADDR_WIDTH  buffer read address, valid with mem_rd
- mem_rdata  in  24  read data, valid exactly 1 cycle after mem_rd; [23:14] I mantissa, [13:4] Q mantissa, [3:0] exponent
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_i  out  16  expanded I, two's complement
- out_q  out  16  expanded Q, two's complement
- exp_err  out  1  sticky: an exponent > 6 was decoded; cleared by the next accepted start

## Operation
- Expansion: out = sign_extend16(mantissa) << exp, zero-filled low bits; exp 0..6 always fits 16 bits, no overflow possible.
- exp 7..15: treated as 6, exp_err set (sticky).
- States: IDLE, RUN, DRAIN.
- IDLE: start with length>0 -> RUN, latch addr/remaining count, clear exp_err, busy=1. start with length=0 -> done pulse next cycle, busy stays 0, no reads.
- RUN: mem_rd=1 when remaining>0 and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready. Each read: mem_addr increments modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1 -> 0), remaining decrements. remaining reaches 0 -> DRAIN.
- DRAIN: wait for inflight=0 and FIFO empty after final pop; then done=1 for one cycle, busy=0, -> IDLE.
- FIFO: 2 entries, stores already-expanded 16-bit I/Q; push on returning read data, pop on handshake; simultaneous push and pop allowed at any count; never overflows given the issue rule.
- out_valid = FIFO non-empty; out_i/out_q = FIFO head; outputs hold stable while out_valid & !out_ready.
- abort (any state): next cycle FIFO flushed, in-flight data discarded, out_valid=0, busy=0, -> IDLE, no done. abort and start in same cycle: abort wins, start ignored.
- start while busy: ignored, no effect on current command.

## Timing
- Reset values: busy 0, done 0, mem_rd 0, mem_addr 0, out_valid 0, out_i 0, out_q 0, exp_err 0; state IDLE, FIFO empty.
- start sampled cycle 0 -> first mem_rd cycle 1 -> data captured end of cycle 2 -> out_valid cycle 3.
- out_ready held high: one sample per cycle from cycle 3; N samples -> last accept cycle N+2, done cycle N+3.
- out_ready low: at most 2 reads outstanding/buffered; reads resume the cycle pop occurs.
- Reset asserted mid-command: all outputs return to reset values immediately; in-flight data ignored after release.

## Test plan
- start_addr=0, length=4, words {mant_i=0x1FF,mant_q=0x200,exp=0}, {0x001,0x3FF,3}, {0x155,0x0AA,6}, {0x200,0x1FF,6}, out_ready=1 -> outputs (0x01FF,0xFE00),(0x0008,0xFFF8),(0x5540,0x2A80),(0x8000,0x7FC0); out_valid cycles 3-6; done cycle 7; exp_err=0.
- length=8, out_ready toggling 1/0 each cycle -> same 8 samples in order, no loss or duplication, mem_rd never has >2 outstanding+buffered, done one cycle after 8th accept.
- start_addr=2^ADDR_WIDTH-2, length=4 -> mem_addr sequence 0x3FE,0x3FF,0x000,0x001.
- word with exp=9, mant_i=0x001 -> out_i=0x0040, exp_err=1 until next start.
- length=0 -> done pulse cycle 1, no mem_rd, busy stays 0; start during busy -> ignored.
- abort at cycle 4 of a length=16 command -> cycle 5 busy=0, out_valid=0, no done; rst mid-command -> all outputs 0 asynchronously.
